// File: rtl/captura_jogada.sv
// Turns debounced board-square lift/place events into a validated move word and holds it
// (temJogada) until the control unit acknowledges with zeraR.
module captura_jogada #(
  parameter int unsigned TIMEOUT_CICLOS = 50_000_000,
  parameter int unsigned LARG_TIMEOUT   = 26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sq_evento,
  input  logic        sq_tipo,
  input  logic [5:0]  sq_codigo,
  input  logic        zeraR,
  output logic        temJogada,
  output logic [11:0] jogada,
  output logic        captura,
  output logic        erro,
  output logic        sobrescrita,
  output logic [3:0]  db_estado
);

  typedef enum logic [1:0] {
    StOcioso  = 2'd0,
    StOrigem  = 2'd1,
    StCaptura = 2'd2,
    StPronta  = 2'd3
  } estado_e;

  localparam logic [LARG_TIMEOUT-1:0] TimerMax = LARG_TIMEOUT'(TIMEOUT_CICLOS - 1);

  estado_e                 estado_q, estado_d;
  logic [5:0]              origem_q, origem_d;
  logic [5:0]              alvo_q, alvo_d;
  logic [11:0]             jogada_q, jogada_d;
  logic                    captura_q, captura_d;
  logic                    tem_jogada_q, tem_jogada_d;
  logic                    erro_q, erro_d;
  logic                    sobrescrita_q, sobrescrita_d;
  logic [LARG_TIMEOUT-1:0] timer_q, timer_d;

  logic levanta, coloca, expirou;

  assign levanta = sq_evento & ~sq_tipo;
  assign coloca  = sq_evento & sq_tipo;
  assign expirou = (timer_q == TimerMax);

  always_comb begin
    estado_d      = estado_q;
    origem_d      = origem_q;
    alvo_d        = alvo_q;
    jogada_d      = jogada_q;
    captura_d     = captura_q;
    tem_jogada_d  = tem_jogada_q;
    erro_d        = 1'b0;
    sobrescrita_d = sobrescrita_q;
    timer_d       = timer_q;

    unique case (estado_q)
      StOcioso: begin
        if (levanta) begin
          origem_d = sq_codigo;
          timer_d  = '0;
          estado_d = StOrigem;
        end else if (coloca) begin
          erro_d = 1'b1;
        end
      end

      StOrigem: begin
        if (coloca) begin
          if (sq_codigo == origem_q) begin
            estado_d = StOcioso;
          end else begin
            jogada_d     = {origem_q, sq_codigo};
            captura_d    = 1'b0;
            tem_jogada_d = 1'b1;
            estado_d     = StPronta;
          end
        end else if (levanta) begin
          if (sq_codigo == origem_q) begin
            erro_d   = 1'b1;
            estado_d = StOcioso;
          end else begin
            alvo_d   = sq_codigo;
            timer_d  = '0;
            estado_d = StCaptura;
          end
        end else if (expirou) begin
          erro_d   = 1'b1;
          estado_d = StOcioso;
        end else begin
          timer_d = timer_q + LARG_TIMEOUT'(1);
        end
      end

      StCaptura: begin
        if (coloca && (sq_codigo == alvo_q)) begin
          jogada_d     = {origem_q, alvo_q};
          captura_d    = 1'b1;
          tem_jogada_d = 1'b1;
          estado_d     = StPronta;
        end else if (coloca && (sq_codigo == origem_q)) begin
          // Cancel; putting the captured piece back later is the user's job.
          estado_d = StOcioso;
        end else if (sq_evento) begin
          erro_d   = 1'b1;
          estado_d = StOcioso;
        end else if (expirou) begin
          erro_d   = 1'b1;
          estado_d = StOcioso;
        end else begin
          timer_d = timer_q + LARG_TIMEOUT'(1);
        end
      end

      StPronta: begin
        // Acknowledge takes priority over (and drops) a simultaneous event.
        if (zeraR) begin
          tem_jogada_d  = 1'b0;
          captura_d     = 1'b0;
          sobrescrita_d = 1'b0;
          estado_d      = StOcioso;
        end else if (sq_evento) begin
          sobrescrita_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q      <= StOcioso;
      origem_q      <= '0;
      alvo_q        <= '0;
      jogada_q      <= '0;
      captura_q     <= 1'b0;
      tem_jogada_q  <= 1'b0;
      erro_q        <= 1'b0;
      sobrescrita_q <= 1'b0;
      timer_q       <= '0;
    end else begin
      estado_q      <= estado_d;
      origem_q      <= origem_d;
      alvo_q        <= alvo_d;
      jogada_q      <= jogada_d;
      captura_q     <= captura_d;
      tem_jogada_q  <= tem_jogada_d;
      erro_q        <= erro_d;
      sobrescrita_q <= sobrescrita_d;
      timer_q       <= timer_d;
    end
  end

  assign temJogada   = tem_jogada_q;
  assign jogada      = jogada_q;
  assign captura     = captura_q;
  assign erro        = erro_q;
  assign sobrescrita = sobrescrita_q;
  assign db_estado   = {2'b00, estado_q};

endmodule

// File: tb/tb_captura_jogada.sv
// Scoreboard bench for captura_jogada: a reference model of the half-move rules queues the
// expected erro pulses and completed moves; a negedge monitor pops and compares them.
module tb_captura_jogada;

  localparam int T = 8;

  logic        clock = 1'b0;
  logic        reset, sq_evento, sq_tipo, zeraR;
  logic [5:0]  sq_codigo;
  logic        temJogada, captura, erro, sobrescrita;
  logic [11:0] jogada;
  logic [3:0]  db_estado;

  captura_jogada #(
    .TIMEOUT_CICLOS(T),
    .LARG_TIMEOUT  (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sq_evento  (sq_evento),
    .sq_tipo    (sq_tipo),
    .sq_codigo  (sq_codigo),
    .zeraR      (zeraR),
    .temJogada  (temJogada),
    .jogada     (jogada),
    .captura    (captura),
    .erro       (erro),
    .sobrescrita(sobrescrita),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_erro;
    logic [11:0] jog;
    bit          cap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   run = 0;

  // Reference model: which piece is in hand, which piece was taken, how long since the lift.
  int          m_org  = -1;
  int          m_alvo = -1;
  int          m_age  = 0;
  bit          m_held = 0;
  bit          m_sob  = 0;
  bit          m_cap  = 0;
  logic [11:0] m_jog  = '0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nome, got, exp, $time);
    end
  endtask

  task automatic push_erro();
    exp_t e;
    e.is_erro = 1; e.jog = '0; e.cap = 0;
    sb.push_back(e);
    m_org = -1; m_alvo = -1;
  endtask

  task automatic push_move(input int o, input int d, input bit c);
    exp_t e;
    e.is_erro = 0; e.jog = 12'(o * 64 + d); e.cap = c;
    sb.push_back(e);
    m_held = 1; m_jog = e.jog; m_cap = c;
    m_org = -1; m_alvo = -1;
  endtask

  task automatic model_step();
    int c;
    c = int'(sq_codigo);
    if (reset) begin
      m_org = -1; m_alvo = -1; m_age = 0;
      m_held = 0; m_sob = 0; m_cap = 0; m_jog = '0;
      sb.delete();
    end else if (m_held) begin
      if (zeraR) begin
        m_held = 0; m_sob = 0; m_cap = 0;
      end else if (sq_evento) begin
        m_sob = 1;
      end
    end else if (m_org < 0) begin
      if (sq_evento && !sq_tipo) begin
        m_org = c; m_age = 0;
      end else if (sq_evento) begin
        push_erro();
      end
    end else if (sq_evento) begin
      if (m_alvo < 0) begin
        if (sq_tipo && c == m_org) m_org = -1;
        else if (sq_tipo) push_move(m_org, c, 0);
        else if (c == m_org) push_erro();
        else begin
          m_alvo = c; m_age = 0;
        end
      end else begin
        if (sq_tipo && c == m_alvo) push_move(m_org, m_alvo, 1);
        else if (sq_tipo && c == m_org) begin
          m_org = -1; m_alvo = -1;
        end else push_erro();
      end
    end else if (m_age == T - 1) begin
      push_erro();
    end else begin
      m_age++;
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Monitor
  initial begin
    bit   prev_tem;
    exp_t e;
    int   code;
    prev_tem = 0;
    forever begin
      @(negedge clock);
      if (run) begin
        if (erro) begin
          if (sb.size() == 0) chk("erro_unexpected", 32'(erro), 32'd0);
          else begin
            e = sb.pop_front();
            chk("erro_kind", 32'(e.is_erro), 32'd1);
          end
        end
        if (temJogada && !prev_tem) begin
          if (sb.size() == 0) chk("move_unexpected", 32'(temJogada), 32'd0);
          else begin
            e = sb.pop_front();
            chk("move_kind", 32'(e.is_erro), 32'd0);
            chk("move_jogada", 32'(jogada), 32'(e.jog));
            chk("move_captura", 32'(captura), 32'(e.cap));
          end
        end
        chk("sb_pending", 32'(sb.size()), 32'd0);
        sb.delete();
        code = m_held ? 3 : (m_alvo >= 0 ? 2 : (m_org >= 0 ? 1 : 0));
        chk("temJogada", 32'(temJogada), 32'(m_held));
        chk("sobrescrita", 32'(sobrescrita), 32'(m_sob));
        chk("db_estado", 32'(db_estado), 32'(code));
        if (m_held) begin
          chk("held_jogada", 32'(jogada), 32'(m_jog));
          chk("held_captura", 32'(captura), 32'(m_cap));
        end
        prev_tem = temJogada;
      end
    end
  end

  task automatic drive(input bit ev, input bit t, input int c, input bit z, input bit r);
    sq_evento = ev; sq_tipo = t; sq_codigo = 6'(c); zeraR = z; reset = r;
    @(posedge clock);
    #1;
    sq_evento = 0; sq_tipo = 0; sq_codigo = '0; zeraR = 0; reset = 0;
  endtask

  task automatic lift(input int c);  drive(1, 0, c, 0, 0); endtask
  task automatic place(input int c); drive(1, 1, c, 0, 0); endtask
  task automatic zera();             drive(0, 0, 0, 1, 0); endtask
  task automatic rst();              drive(0, 0, 0, 0, 1); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tem"}, 32'(temJogada), 32'd0);
    chk({tag, "_jogada"}, 32'(jogada), 32'd0);
    chk({tag, "_captura"}, 32'(captura), 32'd0);
    chk({tag, "_erro"}, 32'(erro), 32'd0);
    chk({tag, "_sob"}, 32'(sobrescrita), 32'd0);
    chk({tag, "_estado"}, 32'(db_estado), 32'd0);
  endtask

  initial begin
    int r;
    sq_evento = 0; sq_tipo = 0; sq_codigo = '0; zeraR = 0; reset = 1;
    rst();
    rst();
    run = 1;
    chk_zero("reset");

    lift(12); place(28);
    chk("simple_tem", 32'(temJogada), 32'd1);
    chk("simple_jogada", 32'(jogada), 32'h31C);
    chk("simple_cap", 32'(captura), 32'd0);
    idle(10);
    chk("simple_hold", 32'(jogada), 32'h31C);
    zera();
    chk("ack_tem", 32'(temJogada), 32'd0);
    chk("ack_estado", 32'(db_estado), 32'd0);

    lift(12); lift(28); place(28);
    chk("capt_jogada", 32'(jogada), 32'h31C);
    chk("capt_cap", 32'(captura), 32'd1);
    zera();

    lift(6); place(6);
    chk("cancel_tem", 32'(temJogada), 32'd0);
    chk("cancel_estado", 32'(db_estado), 32'd0);
    place(9);
    chk("stray_place_erro", 32'(erro), 32'd1);
    idle(1);
    chk("erro_one_cycle", 32'(erro), 32'd0);

    lift(0); idle(8);
    chk("timeout_erro", 32'(erro), 32'd1);
    chk("timeout_estado", 32'(db_estado), 32'd0);
    lift(0); idle(6); place(1);
    chk("late_place_tem", 32'(temJogada), 32'd1);
    chk("late_place_erro", 32'(erro), 32'd0);

    lift(3);
    chk("overwrite_sob", 32'(sobrescrita), 32'd1);
    chk("overwrite_jogada", 32'(jogada), 32'h001);
    drive(1, 1, 5, 1, 0);
    chk("ack_event_sob", 32'(sobrescrita), 32'd0);
    chk("ack_event_estado", 32'(db_estado), 32'd0);

    lift(1); lift(2);
    chk("in_captura", 32'(db_estado), 32'd2);
    rst();
    chk_zero("rst_captura");
    lift(5); place(13);
    rst();
    chk_zero("rst_pronta");
    lift(5); place(13);
    chk("after_rst_jogada", 32'(jogada), 32'h14D);
    zera();

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) rst();
      else if (r < 45)
        drive(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              $urandom_range(0, 4) == 0, 0);
      else if (r < 50) idle(int'($urandom_range(5, 10)));
      else drive(0, 0, 0, $urandom_range(0, 2) == 0, 0);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/captura_jogada.md
Name: captura_jogada

Overview:
- Producer side of the move handshake consumed by the game control unit.
- Turns board square events (piece lifted / piece placed) into one validated move word {origem, destino}, including captures and cancel-by-replace.
- Raises temJogada and holds the move stable until the control unit asserts zeraR (in its fimJogada state).
- Sits between the synchronized board-sensor scanner and the control unit / move-compare datapath.

Parameters:
TIMEOUT_CICLOS, 50_000_000, clock cycles allowed between lift and place before the half-move is abandoned
LARG_TIMEOUT, 26, width of the timeout counter; must satisfy 2^LARG_TIMEOUT > TIMEOUT_CICLOS

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
sq_evento  in  1  one-cycle strobe: a square changed state (already synchronized and debounced)
sq_tipo  in  1  qualifies sq_evento: 0 = piece lifted, 1 = piece placed
sq_codigo  in  6  square index 0..63 (rank*8+file) qualifying sq_evento
zeraR  in  1  control unit acknowledge; clears the held move
temJogada  out  1  a complete move is held on jogada
jogada  out  12  {origem[11:6], destino[5:0]}; valid while temJogada=1
captura  out  1  held move is a capture; valid while temJogada=1
erro  out  1  one-cycle pulse on an illegal event sequence or timeout
sobrescrita  out  1  sticky: an event arrived while a move was held; cleared by zeraR
db_estado  out  4  current state code, for debug display

Behaviour:
- Reset (synchronous, on the clock edge while reset=1): state OCIOSO. temJogada=0, jogada=0, captura=0, erro=0, sobrescrita=0, timeout counter=0. Applies from any state; a partial move is discarded.
- All outputs are registered. Each output changes on the edge after the cycle in which the event was sampled (latency 1).
- States and db_estado codes: OCIOSO=0, ORIGEM=1, CAPTURA=2, PRONTA=3.
- OCIOSO:
  - Lift L: origem<=L, go to ORIGEM, clear the timer.
  - Place: erro pulse, stay in OCIOSO.
- ORIGEM:
  - Place at P != origem: destino<=P, captura<=0, go to PRONTA.
  - Place at P == origem: cancel. Go to OCIOSO, no erro.
  - Lift L != origem: alvo<=L, go to CAPTURA, clear the timer.
  - Lift L == origem: erro, go to OCIOSO.
- CAPTURA:
  - Place at alvo: destino<=alvo, captura<=1, go to PRONTA.
  - Place at origem: cancel. Go to OCIOSO, no erro. Restoring the captured piece is the user's job; that later place event in OCIOSO pulses erro.
  - Any other place, or any lift: erro, go to OCIOSO.
- Timer:
  - Counts each cycle in ORIGEM and CAPTURA.
  - On reaching TIMEOUT_CICLOS-1 with no event that cycle: erro pulse, go to OCIOSO.
  - If an event arrives in that same cycle, the event wins.
- PRONTA:
  - temJogada=1; jogada and captura are held constant.
  - zeraR=1: go to OCIOSO, temJogada<=0, captura<=0, sobrescrita<=0. jogada keeps its old value but is don't-care.
  - sq_evento with zeraR=0: event dropped, sobrescrita<=1, no erro.
  - sq_evento with zeraR=1 in the same cycle: zeraR wins, the event is dropped, and sobrescrita is not set.
- zeraR outside PRONTA is ignored.
- erro is high for exactly one cycle per offending event. It never coincides with temJogada rising.
- sq_codigo and sq_tipo are sampled only when sq_evento=1.

Test Plan:
- Reset, lift 12, place 28, hold zeraR=0 for 10 cycles -> temJogada=1 one cycle after the place; jogada=12'h31C (12<<6|28); captura=0; stable for 10 cycles. Then zeraR pulse -> temJogada=0 on the next edge, db_estado=0.
- Lift 12, lift 28, place 28 -> jogada=12'h31C, captura=1, no erro pulse.
- Lift 6, place 6 -> no temJogada, no erro, db_estado returns to 0. Then place 9 in OCIOSO -> single erro pulse.
- Timeout with TIMEOUT_CICLOS=8: lift 0, wait 8 cycles -> erro pulse on cycle 8, state 0. Repeat with place 1 on cycle 7 -> PRONTA, no erro.
- In PRONTA: event with zeraR=0 -> sobrescrita=1, jogada unchanged. Then event plus zeraR in the same cycle -> OCIOSO, sobrescrita=0.
- Reset asserted in CAPTURA and in PRONTA -> all outputs 0 on the next edge. A subsequent lift 5, place 13 yields jogada=12'h14D.
